add_arbiter: RTL and testbench

- Round-robin arbiter and sequencer for one shared WIDTH-bit adder.
- Serves up to NUM_REQ requesters: PC increment, branch-target calc, address generation, and spare slots.
- Accepts one operand pair per cycle, computes A+B and returns a registered result tagged with the one-hot winner.
- Sits between the CPU control/datapath units and the single adder instance, so that adder does not need to be replicated.

---
 rtl/add_arb_pkg.sv | 13 +
 rtl/rr_picker.sv | 30 +++
 rtl/add_arbiter.sv | 73 +++++++
 tb/tb_add_arbiter.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/add_arb_pkg.sv
// add_arb_pkg: shared constants for the add_arbiter slice (width, requester count, requester ids)
package add_arb_pkg;
    localparam int ADD_ARB_WIDTH   = 32;
    localparam int ADD_ARB_NUM_REQ = 4;
    localparam int ADD_ARB_IDX_W   = 2;
    localparam int REQ_PC    = 0;
    localparam int REQ_BR    = 1;
    localparam int REQ_AGU   = 2;
    localparam int REQ_SPARE = 3;
    function automatic int next_idx(input int i, input int n);
        return (i + 1) % n;
    endfunction
endpackage

// File: rtl/rr_picker.sv
// rr_picker: combinational round-robin pick, scanning from ptr upward with wrap
module rr_picker
    import add_arb_pkg::*;
#(
    parameter int NUM_REQ = ADD_ARB_NUM_REQ,
    parameter int IDX_W   = ADD_ARB_IDX_W
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   idx,
    output logic               any_grant
);
    // first requester at or after ptr (modulo NUM_REQ) wins
    always_comb begin
        int j;
        j         = 0;
        grant     = '0;
        idx       = '0;
        any_grant = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            j = (int'(ptr) + k) % NUM_REQ;
            if (!any_grant && req[j]) begin
                grant[j]  = 1'b1;
                idx       = IDX_W'(j);
                any_grant = 1'b1;
            end
        end
    end
endmodule

// File: rtl/add_arbiter.sv
// add_arbiter: round-robin sharing of one adder, 1-cycle registered result; ADD_ARB_OVF_EN adds rsp_ovf
module add_arbiter
    import add_arb_pkg::*;
#(
    parameter int WIDTH   = ADD_ARB_WIDTH,
    parameter int NUM_REQ = ADD_ARB_NUM_REQ,
    parameter int IDX_W   = ADD_ARB_IDX_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ*WIDTH-1:0] req_a,
    input  logic [NUM_REQ*WIDTH-1:0] req_b,
    output logic [NUM_REQ-1:0]       req_ready,
    output logic [NUM_REQ-1:0]       rsp_valid,
    output logic [IDX_W-1:0]         rsp_idx,
    output logic [WIDTH-1:0]         rsp_result,
    output logic                     rsp_carry
`ifdef ADD_ARB_OVF_EN
    ,
    output logic                     rsp_ovf
`endif
);
    logic [NUM_REQ-1:0] grant;
    logic [IDX_W-1:0]   gidx;
    logic [IDX_W-1:0]   ptr;
    logic               any;
    logic [WIDTH-1:0]   a_sel;
    logic [WIDTH-1:0]   b_sel;
    logic [WIDTH:0]     sum;

    rr_picker #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_pick (
        .req       (req_valid),
        .ptr       (ptr),
        .grant     (grant),
        .idx       (gidx),
        .any_grant (any)
    );

    assign req_ready = rst ? '0 : grant;
    assign a_sel     = req_a[int'(gidx)*WIDTH +: WIDTH];
    assign b_sel     = req_b[int'(gidx)*WIDTH +: WIDTH];
    assign sum       = {1'b0, a_sel} + {1'b0, b_sel};

    // register the winner's sum and advance the pointer past it; idle cycles hold the payload
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr        <= '0;
            rsp_valid  <= '0;
            rsp_idx    <= '0;
            rsp_result <= '0;
            rsp_carry  <= 1'b0;
        end else begin
            rsp_valid <= grant;
            if (any) begin
                rsp_idx    <= gidx;
                rsp_result <= sum[WIDTH-1:0];
                rsp_carry  <= sum[WIDTH];
                ptr        <= IDX_W'(next_idx(int'(gidx), NUM_REQ));
            end
        end
    end

`ifdef ADD_ARB_OVF_EN
    // signed overflow: like-signed operands producing a result of the other sign
    always_ff @(posedge clk) begin
        if (rst)
            rsp_ovf <= 1'b0;
        else if (any)
            rsp_ovf <= (a_sel[WIDTH-1] == b_sel[WIDTH-1]) && (sum[WIDTH-1] != a_sel[WIDTH-1]);
    end
`endif
endmodule

// File: tb/tb_add_arbiter.sv
// tb_add_arbiter: directed + random checks of add_arbiter against a behavioural model (ADD_ARB_OVF_EN aware)
module tb_add_arbiter;
    localparam int W = 32;
    localparam int N = 4;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [N-1:0]   req_valid = '0;
    logic [N*W-1:0] req_a = '0;
    logic [N*W-1:0] req_b = '0;
    logic [N-1:0]   req_ready;
    logic [N-1:0]   rsp_valid;
    logic [1:0]     rsp_idx;
    logic [W-1:0]   rsp_result;
    logic           rsp_carry;
`ifdef ADD_ARB_OVF_EN
    logic           rsp_ovf;
`endif

    int checks = 0;
    int passed = 0;

    int           m_ptr = 0;
    logic [N-1:0] e_valid = '0;
    int           e_idx = 0;
    logic [W-1:0] e_res = '0;
    logic         e_carry = 1'b0;
    logic         e_ovf = 1'b0;
    int           last_grant = -1;

    add_arbiter #(.WIDTH(W), .NUM_REQ(N), .IDX_W(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_ready  (req_ready),
        .rsp_valid  (rsp_valid),
        .rsp_idx    (rsp_idx),
        .rsp_result (rsp_result),
        .rsp_carry  (rsp_carry)
`ifdef ADD_ARB_OVF_EN
        ,
        .rsp_ovf    (rsp_ovf)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic chk_rsp(input string tag);
        chk({tag, ".rsp_valid"}, 64'(rsp_valid), 64'(e_valid));
        chk({tag, ".rsp_idx"}, 64'(rsp_idx), 64'(e_idx));
        chk({tag, ".rsp_result"}, 64'(rsp_result), 64'(e_res));
        chk({tag, ".rsp_carry"}, 64'(rsp_carry), 64'(e_carry));
`ifdef ADD_ARB_OVF_EN
        chk({tag, ".rsp_ovf"}, 64'(rsp_ovf), 64'(e_ovf));
`endif
    endtask

    // called at a negedge; holds rst for n cycles with the given requests present
    task automatic do_reset(input int n, input logic [N-1:0] v);
        rst = 1'b1;
        req_valid = v;
        for (int c = 0; c < n; c++) begin
            #1;
            chk("reset.req_ready", 64'(req_ready), 64'd0);
            @(posedge clk);
            m_ptr = 0; e_valid = '0; e_idx = 0; e_res = '0; e_carry = 1'b0; e_ovf = 1'b0;
            @(negedge clk);
            chk_rsp("reset");
        end
        rst = 1'b0;
        req_valid = '0;
    endtask

    // one cycle of traffic: model picks the first requester at or after m_ptr in circular order
    task automatic step(input string tag, input logic [N-1:0] v, input logic [N*W-1:0] a, input logic [N*W-1:0] b);
        int w;
        logic [W:0] s;
        longint ss;
        logic [W-1:0] aw, bw;
        w = -1;
        for (int k = 0; k < N; k++)
            if (w < 0 && v[(m_ptr + k) % N]) w = (m_ptr + k) % N;
        req_valid = v; req_a = a; req_b = b;
        #1;
        chk({tag, ".req_ready"}, 64'(req_ready), (w >= 0) ? (64'd1 << w) : 64'd0);
        @(posedge clk);
        if (w >= 0) begin
            aw = a[w*W +: W];
            bw = b[w*W +: W];
            s = {1'b0, aw} + {1'b0, bw};
            ss = longint'($signed(aw)) + longint'($signed(bw));
            e_valid = N'(1) << w;
            e_idx = w;
            e_res = s[W-1:0];
            e_carry = s[W];
            e_ovf = (ss > 64'sd2147483647) || (ss < -64'sd2147483648);
            m_ptr = (w + 1) % N;
            last_grant = w;
        end else begin
            e_valid = '0;
        end
        @(negedge clk);
        chk_rsp(tag);
    endtask

    function automatic logic [N*W-1:0] rnd_ops();
        logic [N*W-1:0] r;
        for (int i = 0; i < N; i++) r[i*W +: W] = $urandom;
        return r;
    endfunction

    function automatic logic [N*W-1:0] one_op(input int i, input logic [W-1:0] x);
        logic [N*W-1:0] r;
        r = '0;
        r[i*W +: W] = x;
        return r;
    endfunction

    initial begin
        int prev;
        @(negedge clk);
        do_reset(3, 4'b1111);

        for (int c = 0; c < 8; c++) begin
            step("rotate", 4'b1111, rnd_ops(), rnd_ops());
            chk("rotate.order", 64'(last_grant), 64'(c % N));
        end

        step("single", 4'b0010, one_op(1, 32'h0000_0004), one_op(1, 32'h0040_0000));
        chk("single.result_const", 64'(rsp_result), 64'h0040_0004);

        step("idle", 4'b0000, rnd_ops(), rnd_ops());

        step("carry", 4'b0001, one_op(0, 32'hFFFF_FFFF), one_op(0, 32'h0000_0002));
        chk("carry.result_const", 64'(rsp_result), 64'h1);
        chk("carry.carry_const", 64'(rsp_carry), 64'h1);
        step("sovf", 4'b0001, one_op(0, 32'h7FFF_FFFF), one_op(0, 32'h0000_0001));
`ifdef ADD_ARB_OVF_EN
        chk("sovf.ovf_const", 64'(rsp_ovf), 64'h1);
`endif

        step("fair.pre", 4'b1000, rnd_ops(), rnd_ops());
        prev = last_grant;
        for (int c = 0; c < 6; c++) begin
            step("fair", 4'b1001, rnd_ops(), rnd_ops());
            chk("fair.alternate", 64'(last_grant), (prev == 3) ? 64'd0 : 64'd3);
            prev = last_grant;
        end

        step("mid.accept", 4'b0010, rnd_ops(), rnd_ops());
        do_reset(1, 4'b0010);
        step("mid.after", 4'b1100, rnd_ops(), rnd_ops());
        chk("mid.grant2", 64'(last_grant), 64'd2);

        for (int c = 0; c < 60; c++)
            step("random", N'($urandom_range(0, 15)), rnd_ops(), rnd_ops());

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
